// File: rtl/token_delay_pipe.sv
// Fixed-latency token pipeline: tokens emerge DEPTH cycles after acceptance, with a credit
// counter capping tokens in flight. Define TOKEN_PIPE_CHECK_EN to build the occupancy checker behind err.
module token_delay_pipe #(
  parameter int DEPTH        = 5,
  parameter int WIDTH        = 8,
  parameter int MAX_INFLIGHT = 1,
  localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] inflight,
  output logic             full,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W:0]   cnt_ext;
  logic             accept;

  always_comb begin
    in_ready = rst && (inflight_q < MAX_CNT) && !flush;
    accept   = in_valid && in_ready;
  end

  // Data moves only alongside a valid bit, so an idle or flushed slot never
  // overwrites what the consumer last saw on out_data.
  always_comb begin
    vld_d    = '0;
    dat_d    = dat_q;
    vld_d[0] = accept;
    if (accept) begin
      dat_d[0] = in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1] && !flush) begin
        dat_d[i] = dat_q[i-1];
      end
    end
    if (flush) begin
      vld_d = '0;
    end
  end

  always_comb begin
    cnt_ext = {1'b0, inflight_q} + {{CNT_W{1'b0}}, accept};
    if (out_valid && (cnt_ext != '0)) begin
      cnt_ext = cnt_ext - 1'b1;
    end
    if (cnt_ext > {1'b0, MAX_CNT}) begin
      cnt_ext = {1'b0, MAX_CNT};
    end
    inflight_d = flush ? '0 : cnt_ext[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q      <= '0;
      inflight_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q      <= vld_d;
      dat_q      <= dat_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    out_valid = vld_q[DEPTH-1];
    out_data  = dat_q[DEPTH-1];
    inflight  = inflight_q;
    full      = (inflight_q == MAX_CNT);
  end

`ifdef TOKEN_PIPE_CHECK_EN
  logic [6:0] pop_cnt;
  logic       mismatch;
  logic       err_q, err_d;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pop_cnt = pop_cnt + 7'(vld_q[i]);
    end
    mismatch = (pop_cnt != 7'(inflight_q)) || (pop_cnt > 7'(MAX_INFLIGHT));
    err_d    = flush ? 1'b0 : (err_q || mismatch);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_token_delay_pipe.sv
// Randomized scoreboard bench for token_delay_pipe: a queue model of in-flight tokens
// predicts admission, occupancy and exit timing; a separate monitor checks every exit.
module tb_token_delay_pipe;
  localparam int DEPTH   = 4;
  localparam int WIDTH   = 8;
  localparam int MAX_INF = 2;
  localparam int CW      = $clog2(MAX_INF + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    inflight;
  logic             full;
  logic             err;

  token_delay_pipe #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MAX_INFLIGHT(MAX_INF)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .inflight(inflight), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               exit_t;
  } tok_t;

  tok_t             sb[$];
  int               live[$];
  int               now = 0;
  int               checks = 0;
  int               passes = 0;
  logic [WIDTH-1:0] last_out = '0;
  bit               mon_en = 1'b0;

  always @(posedge clk) now++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Monitor: every presented token must be the oldest expected one, on its exact exit cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("out_valid_unexpected", int'(out_valid), 0);
        end else begin
          tok_t t;
          t = sb.pop_front();
          chk("out_time", now, t.exit_t);
          chk("out_data", int'(out_data), int'(t.data));
          last_out = t.data;
        end
      end else begin
        chk("out_data_hold", int'(out_data), int'(last_out));
        if (sb.size() > 0 && sb[0].exit_t <= now) begin
          chk("out_valid_missing", int'(out_valid), 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit f, output bit acc);
    bit exp_ready;
    @(negedge clk);
    #1;
    while (live.size() > 0 && live[0] < now) void'(live.pop_front());
    chk("inflight", int'(inflight), live.size());
    chk("full", int'(full), int'(live.size() == MAX_INF));
    chk("err", int'(err), 0);
    in_valid = v;
    in_data  = d;
    flush    = f;
    #1;
    exp_ready = (live.size() < MAX_INF) && !f;
    chk("in_ready", int'(in_ready), int'(exp_ready));
    acc = v && exp_ready;
    if (f) begin
      live.delete();
      sb.delete();
    end else if (acc) begin
      live.push_back(now + DEPTH);
      sb.push_back(tok_t'{d, now + DEPTH});
    end
  endtask

  initial begin
    bit               acc;
    logic [WIDTH-1:0] seq;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_inflight", int'(inflight), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_err", int'(err), 0);
    rst    = 1'b1;
    mon_en = 1'b1;

    // Continuous offer with sequential payloads: exercises full/no same-cycle credit return.
    seq = 8'd1;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, seq, 1'b0, acc);
      if (acc) seq++;
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b0, acc);

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 19) == 0, acc);
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b0, acc);

    // Flush with two tokens in flight; the monitor flags any leak.
    cycle(1'b1, 8'h3C, 1'b0, acc);
    cycle(1'b1, 8'hC3, 1'b0, acc);
    cycle(1'b0, 8'h00, 1'b1, acc);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b0, acc);

    // Asynchronous reset mid-cycle with two tokens in flight.
    cycle(1'b1, 8'h11, 1'b0, acc);
    cycle(1'b1, 8'h22, 1'b0, acc);
    cycle(1'b0, 8'h00, 1'b0, acc);
    @(posedge clk);
    #3;
    rst    = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_inflight", int'(inflight), 0);
    chk("arst_full", int'(full), 0);
    chk("arst_in_ready", int'(in_ready), 0);
    chk("arst_out_data", int'(out_data), 0);
    sb.delete();
    live.delete();
    last_out = '0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 30; i++) cycle($urandom_range(0, 1) != 0, WIDTH'($urandom), 1'b0, acc);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b0, acc);
    chk("sb_drained", sb.size(), 0);

`ifdef TOKEN_PIPE_CHECK_EN
    mon_en = 1'b0;
    @(negedge clk);
    #1;
    force dut.inflight_q = CW'(1);
    @(negedge clk);
    #1;
    release dut.inflight_q;
    chk("chk_err_set", int'(err), 1);
    @(negedge clk);
    #1;
    chk("chk_err_sticky", int'(err), 1);
    flush = 1'b1;
    @(negedge clk);
    #1;
    flush = 1'b0;
    chk("chk_err_flush", int'(err), 0);
    chk("chk_inflight_flush", int'(inflight), 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
